data_ram_responder: RTL and testbench

- Target-side data memory for the MEM stage's RAM request interface.
- Accepts chip-enable, write-request, address and word data; returns read data, a ready strobe and an error flag.
- Read-modify-write for byte and halfword stores happens in the MEM stage, so this block only ever reads or writes whole aligned words.
- Adds configurable wait states, so the pipeline can later be stalled on `ram_ready_o`.

---
 rtl/data_ram_responder.sv | 145 ++++++++++++++
 tb/tb_data_ram_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_responder.sv
// Word-addressed data RAM behind the MEM-stage request interface.
// WAIT_CYCLES=0 gives a combinational responder; otherwise a latched request is answered after a fixed busy period.
module data_ram_responder #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 2,
  parameter string                 INIT_FILE   = ""
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ram_ce_i,
  input  logic                  ram_w_request_i,
  input  logic [ADDR_WIDTH-1:0] ram_addr_i,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic                  ram_ready_o,
  output logic                  ram_err_o
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(4 * DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  // Offset in ADDR_WIDTH bits: addresses below BASE_ADDR wrap high and fail the range test.
  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_range;
  logic [IW-1:0]         index;

  assign offset   = ram_addr_i - BASE_ADDR;
  assign in_range = {1'b0, offset} < SPAN;
  assign index    = offset[IW+1:2];

  generate
    if (WAIT_CYCLES == 0) begin : g_zero_wait
      logic unused_zw;
      assign unused_zw = ^{offset[1:0], rst_i};

      assign ram_ready_o = ram_ce_i;
      assign ram_err_o   = ram_ce_i & ~in_range;
      // Combinational read sees the pre-edge contents, so a same-cycle write is not forwarded.
      assign ram_data_o  = (ram_ce_i && !ram_w_request_i && in_range) ? mem[index] : '0;

      always_ff @(posedge clk_i) begin
        if (ram_ce_i && ram_w_request_i && in_range) mem[index] <= ram_data_i;
      end
    end else begin : g_wait
      localparam int CW = $clog2(WAIT_CYCLES + 1);

      typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

      state_e                state_q, state_d;
      logic [CW-1:0]         cnt_q, cnt_d;
      logic [IW-1:0]         idx_q, idx_d;
      logic                  we_q, we_d;
      logic                  inr_q, inr_d;
      logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
      logic [DATA_WIDTH-1:0] data_q, data_d;
      logic                  ready_q, ready_d;
      logic                  err_q, err_d;
      logic                  unused_w;

      assign unused_w = ^offset[1:0];

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          idx_q   <= '0;
          we_q    <= 1'b0;
          inr_q   <= 1'b0;
          wdata_q <= '0;
          data_q  <= '0;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          idx_q   <= idx_d;
          we_q    <= we_d;
          inr_q   <= inr_d;
          wdata_q <= wdata_d;
          data_q  <= data_d;
          ready_q <= ready_d;
          err_q   <= err_d;
        end
      end

      // Response outputs are computed on the last BUSY cycle so they are registered during RESP.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        inr_d   = inr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
          IDLE: begin
            if (ram_ce_i) begin
              idx_d   = index;
              we_d    = ram_w_request_i;
              inr_d   = in_range;
              wdata_d = ram_data_i;
              cnt_d   = CW'(WAIT_CYCLES);
              state_d = BUSY;
            end
          end
          BUSY: begin
            if (!ram_ce_i) begin
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q - CW'(1);
              if (cnt_q == CW'(1)) begin
                state_d = RESP;
                ready_d = 1'b1;
                err_d   = ~inr_q;
                if (!we_q) data_d = inr_q ? mem[idx_q] : '0;
              end
            end
          end
          RESP:    state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end

      always_ff @(posedge clk_i) begin
        if (!rst_i && state_q == RESP && we_q && inr_q) mem[idx_q] <= wdata_q;
      end

      assign ram_data_o  = data_q;
      assign ram_ready_o = ready_q;
      assign ram_err_o   = err_q;
    end
  endgenerate

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder: a wait-state instance (WAIT_CYCLES=2)
// and a zero-wait instance (WAIT_CYCLES=0) share clock and reset.
module tb_data_ram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        w_ce = 1'b1, w_we = 1'b0;
  logic [31:0] w_addr = '0, w_wdata = '0;
  logic [31:0] w_rdata;
  logic        w_ready, w_err;

  logic        z_ce = 1'b0, z_we = 1'b0;
  logic [31:0] z_addr = '0, z_wdata = '0;
  logic [31:0] z_rdata;
  logic        z_ready, z_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_ram_responder #(.WAIT_CYCLES(2)) dut_w (
    .clk_i(clk), .rst_i(rst), .ram_ce_i(w_ce), .ram_w_request_i(w_we),
    .ram_addr_i(w_addr), .ram_data_i(w_wdata),
    .ram_data_o(w_rdata), .ram_ready_o(w_ready), .ram_err_o(w_err)
  );

  data_ram_responder #(.WAIT_CYCLES(0)) dut_z (
    .clk_i(clk), .rst_i(rst), .ram_ce_i(z_ce), .ram_w_request_i(z_we),
    .ram_addr_i(z_addr), .ram_data_i(z_wdata),
    .ram_data_o(z_rdata), .ram_ready_o(z_ready), .ram_err_o(z_err)
  );

  // One request on the wait-state instance; lat is the cycle index of the ready pulse, -1 if none.
  task automatic w_xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    logic seen;
    seen  = 1'b0;
    lat   = -1;
    rdata = 'x;
    err   = 1'bx;
    @(posedge clk); #1;
    w_ce = 1'b1; w_we = we; w_addr = addr; w_wdata = wdata;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (w_ready) begin
        seen = 1'b1; lat = k; rdata = w_rdata; err = w_err;
      end
      @(posedge clk); #1;
    end
    w_ce = 1'b0; w_we = 1'b0;
  endtask

  task automatic test_reset;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (w_ready !== 1'b0 || w_err !== 1'b0 || w_rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_c%0d: ready=%b err=%b data=%h, want 0 0 00000000", c, w_ready, w_err, w_rdata);
      end
    end
    #1; // negedge + 1: drop ce and release reset before the next rising edge
    w_ce = 1'b0;
    rst  = 1'b0;
  endtask

  task automatic test_write_read;
    logic [31:0] d; logic e; int lat;
    w_xact(1'b1, 32'h10, 32'hDEADBEEF, d, e, lat);
    n_checks++;
    if (lat !== 3 || e !== 1'b0) begin
      n_fail++; $display("FAIL wr_0x10: lat=%0d err=%b, want 3 0", lat, e);
    end
    @(negedge clk);
    n_checks++;
    if (w_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_one_cycle: ready=%b, want 0", w_ready);
    end
    w_xact(1'b0, 32'h10, 32'h0, d, e, lat);
    n_checks++;
    if (lat !== 3 || e !== 1'b0 || d !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rd_0x10: lat=%0d err=%b data=%h, want 3 0 deadbeef", lat, e, d);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (w_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rd_hold: data=%h, want deadbeef", w_rdata);
    end
  endtask

  task automatic test_addr_bits;
    logic [31:0] d; logic e; int lat;
    w_xact(1'b1, 32'h22, 32'h11223344, d, e, lat);
    w_xact(1'b0, 32'h20, 32'h0, d, e, lat);
    n_checks++;
    if (lat !== 3 || e !== 1'b0 || d !== 32'h11223344) begin
      n_fail++; $display("FAIL addr_lsb_ignored: lat=%0d err=%b data=%h, want 3 0 11223344", lat, e, d);
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] d; logic e; int lat;
    w_xact(1'b1, 32'h1000, 32'hFFFFFFFF, d, e, lat);
    n_checks++;
    if (lat !== 3 || e !== 1'b1) begin
      n_fail++; $display("FAIL oor_wr: lat=%0d err=%b, want 3 1", lat, e);
    end
    w_xact(1'b0, 32'h0, 32'h0, d, e, lat);
    n_checks++;
    if (e !== 1'b0 || d !== 32'h0) begin
      n_fail++; $display("FAIL oor_no_alias: err=%b data=%h, want 0 00000000", e, d);
    end
    w_xact(1'b0, 32'hFFFFFFFC, 32'h0, d, e, lat);
    n_checks++;
    if (lat !== 3 || e !== 1'b1 || d !== 32'h0) begin
      n_fail++; $display("FAIL oor_rd_top: lat=%0d err=%b data=%h, want 3 1 00000000", lat, e, d);
    end
    w_xact(1'b1, 32'hFFC, 32'h0BADF00D, d, e, lat);
    w_xact(1'b0, 32'hFFC, 32'h0, d, e, lat);
    n_checks++;
    if (e !== 1'b0 || d !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL last_word: err=%b data=%h, want 0 0badf00d", e, d);
    end
  endtask

  task automatic test_abort;
    logic [31:0] d; logic e; int lat; int pulses;
    w_xact(1'b1, 32'h40, 32'h13579BDF, d, e, lat);
    pulses = 0;
    @(posedge clk); #1;
    w_ce = 1'b1; w_we = 1'b1; w_addr = 32'h40; w_wdata = 32'hAAAA5555;
    @(negedge clk); if (w_ready) pulses++;
    @(posedge clk); #1;
    w_ce = 1'b0; w_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); if (w_ready) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL abort_no_ready: pulses=%0d, want 0", pulses);
    end
    w_xact(1'b0, 32'h40, 32'h0, d, e, lat);
    n_checks++;
    if (d !== 32'h13579BDF) begin
      n_fail++; $display("FAIL abort_no_write: data=%h, want 13579bdf", d);
    end
  endtask

  task automatic test_latched_request;
    logic [31:0] d; logic e; int lat;
    lat = -1; d = 'x;
    @(posedge clk); #1;
    w_ce = 1'b1; w_we = 1'b0; w_addr = 32'h10;
    @(posedge clk); #1;
    w_addr = 32'h20; w_we = 1'b1; w_wdata = 32'h55555555;
    for (int k = 1; k < 10 && lat < 0; k++) begin
      @(negedge clk);
      if (w_ready) begin lat = k; d = w_rdata; end
      @(posedge clk); #1;
    end
    w_ce = 1'b0; w_we = 1'b0;
    n_checks++;
    if (lat !== 3 || d !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL latched_req: lat=%0d data=%h, want 3 deadbeef", lat, d);
    end
    w_xact(1'b0, 32'h20, 32'h0, d, e, lat);
    n_checks++;
    if (d !== 32'h11223344) begin
      n_fail++; $display("FAIL latched_no_write: data=%h, want 11223344", d);
    end
  endtask

  task automatic test_zero_wait;
    @(posedge clk); #1;
    z_ce = 1'b1; z_we = 1'b0; z_addr = 32'h8;
    #1;
    n_checks++;
    if (z_ready !== 1'b1 || z_err !== 1'b0 || z_rdata !== 32'h0) begin
      n_fail++; $display("FAIL zw_rd_old: ready=%b err=%b data=%h, want 1 0 00000000", z_ready, z_err, z_rdata);
    end
    z_we = 1'b1; z_wdata = 32'h12345678;
    #1;
    n_checks++;
    if (z_ready !== 1'b1 || z_rdata !== 32'h0) begin
      n_fail++; $display("FAIL zw_wr_cycle: ready=%b data=%h, want 1 00000000", z_ready, z_rdata);
    end
    @(posedge clk); #1;
    z_we = 1'b0;
    #1;
    n_checks++;
    if (z_rdata !== 32'h12345678) begin
      n_fail++; $display("FAIL zw_rd_new: data=%h, want 12345678", z_rdata);
    end
    z_ce = 1'b0;
    #1;
    n_checks++;
    if (z_ready !== 1'b0 || z_rdata !== 32'h0) begin
      n_fail++; $display("FAIL zw_ce_low: ready=%b data=%h, want 0 00000000", z_ready, z_rdata);
    end
    z_ce = 1'b1; z_addr = 32'h1000;
    #1;
    n_checks++;
    if (z_ready !== 1'b1 || z_err !== 1'b1 || z_rdata !== 32'h0) begin
      n_fail++; $display("FAIL zw_oor: ready=%b err=%b data=%h, want 1 1 00000000", z_ready, z_err, z_rdata);
    end
    z_we = 1'b1; z_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    z_we = 1'b0; z_addr = 32'h0;
    #1;
    n_checks++;
    if (z_rdata !== 32'h0 || z_err !== 1'b0) begin
      n_fail++; $display("FAIL zw_oor_no_alias: err=%b data=%h, want 0 00000000", z_err, z_rdata);
    end
    z_ce = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_addr_bits();
    test_out_of_range();
    test_abort();
    test_latched_request();
    test_zero_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
